// File: rtl/hazard_track.sv
// Destination-tag pipeline (EXE/MEM/WB) with forwarding data, stall/flush counters
// and a sticky flag for load-use stalls that last longer than one cycle.
module hazard_track (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_wreg,
    input  logic        id_mem2reg,
    input  logic [4:0]  id_regw_addr,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] exe_alu_result,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  exe_regw_addr,
    output logic        exe_wreg,
    output logic        exe_mem2reg,
    output logic [4:0]  mem_regw_addr,
    output logic        mem_wreg,
    output logic        mem_mem2reg,
    output logic [4:0]  wb_regw_addr,
    output logic        wb_wreg,
    output logic [31:0] fwd_mem_data,
    output logic [31:0] fwd_wb_data,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        stall_err
);

    logic [4:0]  r_exe_addr;
    logic        r_exe_wreg;
    logic        r_exe_m2r;
    logic [4:0]  r_mem_addr;
    logic        r_mem_wreg;
    logic        r_mem_m2r;
    logic [31:0] r_mem_alu;
    logic [4:0]  r_wb_addr;
    logic        r_wb_wreg;
    logic [31:0] r_wb_data;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        r_stall_q;
    logic        r_stall_err;

    logic w_bubble;
    logic w_dst_nonzero;

    assign w_bubble      = stall | flush | ~id_valid;
    // $0 is hardwired, so an instruction targeting it must never become a forwarding source
    assign w_dst_nonzero = (id_regw_addr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exe_addr  <= 5'd0;
            r_exe_wreg  <= 1'b0;
            r_exe_m2r   <= 1'b0;
            r_mem_addr  <= 5'd0;
            r_mem_wreg  <= 1'b0;
            r_mem_m2r   <= 1'b0;
            r_mem_alu   <= 32'd0;
            r_wb_addr   <= 5'd0;
            r_wb_wreg   <= 1'b0;
            r_wb_data   <= 32'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
            r_stall_q   <= 1'b0;
            r_stall_err <= 1'b0;
        end else begin
            if (w_bubble) begin
                r_exe_addr <= 5'd0;
                r_exe_wreg <= 1'b0;
                r_exe_m2r  <= 1'b0;
            end else begin
                r_exe_addr <= id_regw_addr;
                r_exe_wreg <= id_wreg & w_dst_nonzero;
                r_exe_m2r  <= id_mem2reg & w_dst_nonzero;
            end

            // MEM and WB keep draining while decode is stalled
            r_mem_addr <= r_exe_addr;
            r_mem_wreg <= r_exe_wreg;
            r_mem_m2r  <= r_exe_m2r;
            r_mem_alu  <= exe_alu_result;

            r_wb_addr  <= r_mem_addr;
            r_wb_wreg  <= r_mem_wreg;
            r_wb_data  <= r_mem_m2r ? mem_rdata : r_mem_alu;

            if (stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end

            r_stall_q <= stall;
            if (stall && r_stall_q) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign exe_regw_addr = r_exe_addr;
    assign exe_wreg      = r_exe_wreg;
    assign exe_mem2reg   = r_exe_m2r;
    assign mem_regw_addr = r_mem_addr;
    assign mem_wreg      = r_mem_wreg;
    assign mem_mem2reg   = r_mem_m2r;
    assign wb_regw_addr  = r_wb_addr;
    assign wb_wreg       = r_wb_wreg;
    assign fwd_mem_data  = r_mem_alu;
    assign fwd_wb_data   = r_wb_data;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;
    assign stall_err     = r_stall_err;

endmodule

// File: tb/tb_hazard_track.sv
// Self-checking bench for hazard_track: vector table through a scoreboard queue,
// plus hand-written double-stall, async-reset and counter-saturation sequences.
module tb_hazard_track;

    typedef struct {
        logic        valid;
        logic        wreg;
        logic        m2r;
        logic [4:0]  addr;
        logic        st;
        logic        fl;
        logic [31:0] alu;
        logic [31:0] rdata;
    } in_t;

    typedef struct {
        logic [4:0]  exe_a;
        logic        exe_w;
        logic        exe_m;
        logic [4:0]  mem_a;
        logic        mem_w;
        logic        mem_m;
        logic [4:0]  wb_a;
        logic        wb_w;
        logic [31:0] fmem;
        logic [31:0] fwb;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        err;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_wreg;
    logic        id_mem2reg;
    logic [4:0]  id_regw_addr;
    logic        stall;
    logic        flush;
    logic [31:0] exe_alu_result;
    logic [31:0] mem_rdata;
    logic [4:0]  exe_regw_addr;
    logic        exe_wreg;
    logic        exe_mem2reg;
    logic [4:0]  mem_regw_addr;
    logic        mem_wreg;
    logic        mem_mem2reg;
    logic [4:0]  wb_regw_addr;
    logic        wb_wreg;
    logic [31:0] fwd_mem_data;
    logic [31:0] fwd_wb_data;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        stall_err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    vec_t vecs[10];
    exp_t zero_e;

    hazard_track dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_wreg        (id_wreg),
        .id_mem2reg     (id_mem2reg),
        .id_regw_addr   (id_regw_addr),
        .stall          (stall),
        .flush          (flush),
        .exe_alu_result (exe_alu_result),
        .mem_rdata      (mem_rdata),
        .exe_regw_addr  (exe_regw_addr),
        .exe_wreg       (exe_wreg),
        .exe_mem2reg    (exe_mem2reg),
        .mem_regw_addr  (mem_regw_addr),
        .mem_wreg       (mem_wreg),
        .mem_mem2reg    (mem_mem2reg),
        .wb_regw_addr   (wb_regw_addr),
        .wb_wreg        (wb_wreg),
        .fwd_mem_data   (fwd_mem_data),
        .fwd_wb_data    (fwd_wb_data),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .stall_err      (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare(input exp_t e, input string tag);
        chk({tag, ".exe_regw_addr"}, 32'(exe_regw_addr), 32'(e.exe_a));
        chk({tag, ".exe_wreg"},      32'(exe_wreg),      32'(e.exe_w));
        chk({tag, ".exe_mem2reg"},   32'(exe_mem2reg),   32'(e.exe_m));
        chk({tag, ".mem_regw_addr"}, 32'(mem_regw_addr), 32'(e.mem_a));
        chk({tag, ".mem_wreg"},      32'(mem_wreg),      32'(e.mem_w));
        chk({tag, ".mem_mem2reg"},   32'(mem_mem2reg),   32'(e.mem_m));
        chk({tag, ".wb_regw_addr"},  32'(wb_regw_addr),  32'(e.wb_a));
        chk({tag, ".wb_wreg"},       32'(wb_wreg),       32'(e.wb_w));
        chk({tag, ".fwd_mem_data"},  fwd_mem_data,       e.fmem);
        chk({tag, ".fwd_wb_data"},   fwd_wb_data,        e.fwb);
        chk({tag, ".stall_cnt"},     32'(stall_cnt),     32'(e.sc));
        chk({tag, ".flush_cnt"},     32'(flush_cnt),     32'(e.fc));
        chk({tag, ".stall_err"},     32'(stall_err),     32'(e.err));
    endtask

    task automatic drive(input in_t i);
        id_valid       = i.valid;
        id_wreg        = i.wreg;
        id_mem2reg     = i.m2r;
        id_regw_addr   = i.addr;
        stall          = i.st;
        flush          = i.fl;
        exe_alu_result = i.alu;
        mem_rdata      = i.rdata;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s.scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            compare(e, tag);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check 1 time unit after the edge
    task automatic apply(input in_t i, input exp_t e, input string tag);
        @(negedge clk);
        drive(i);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    in_t  idle_i;
    in_t  ti;
    exp_t te;

    initial begin
        idle_i = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0};
        zero_e = '{5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 16'd0, 16'd0, 1'b0};

        vecs[0] = '{'{1, 1, 0, 5'd5, 0, 0, 32'h0, 32'h0},
                    '{5'd5, 1, 0, 5'd0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 16'd0, 16'd0, 0}};
        vecs[1] = '{'{1, 1, 1, 5'd3, 0, 0, 32'h1234, 32'h0},
                    '{5'd3, 1, 1, 5'd5, 1, 0, 5'd0, 0, 32'h1234, 32'h0, 16'd0, 16'd0, 0}};
        vecs[2] = '{'{1, 1, 0, 5'd7, 1, 0, 32'h40, 32'h0},
                    '{5'd0, 0, 0, 5'd3, 1, 1, 5'd5, 1, 32'h40, 32'h1234, 16'd1, 16'd0, 0}};
        vecs[3] = '{'{1, 1, 0, 5'd7, 0, 0, 32'h0, 32'hCAFE},
                    '{5'd7, 1, 0, 5'd0, 0, 0, 5'd3, 1, 32'h0, 32'hCAFE, 16'd1, 16'd0, 0}};
        vecs[4] = '{'{1, 1, 0, 5'd9, 0, 1, 32'h77, 32'h0},
                    '{5'd0, 0, 0, 5'd7, 1, 0, 5'd0, 0, 32'h77, 32'h0, 16'd1, 16'd1, 0}};
        vecs[5] = '{'{1, 1, 0, 5'd0, 0, 0, 32'h11, 32'h0},
                    '{5'd0, 0, 0, 5'd0, 0, 0, 5'd7, 1, 32'h11, 32'h77, 16'd1, 16'd1, 0}};
        vecs[6] = '{'{0, 1, 0, 5'd12, 0, 0, 32'h22, 32'h0},
                    '{5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 32'h22, 32'h11, 16'd1, 16'd1, 0}};
        vecs[7] = '{'{1, 0, 0, 5'd4, 0, 0, 32'h33, 32'h0},
                    '{5'd4, 0, 0, 5'd0, 0, 0, 5'd0, 0, 32'h33, 32'h22, 16'd1, 16'd1, 0}};
        vecs[8] = '{'{1, 1, 0, 5'd6, 1, 1, 32'h44, 32'h0},
                    '{5'd0, 0, 0, 5'd4, 0, 0, 5'd0, 0, 32'h44, 32'h33, 16'd2, 16'd2, 0}};
        vecs[9] = '{'{0, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0},
                    '{5'd0, 0, 0, 5'd0, 0, 0, 5'd4, 0, 32'h0, 32'h44, 16'd2, 16'd2, 0}};

        rst = 1'b1;
        drive(idle_i);
        repeat (2) @(posedge clk);
        #1;
        compare(zero_e, "reset");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            apply(vecs[k].i, vecs[k].e, $sformatf("row%0d", k));
        end

        // Double stall: the flag sets on the second cycle and stays until reset
        ti = idle_i;
        ti.st = 1'b1;
        te = zero_e;
        te.sc = 16'd3; te.fc = 16'd2;
        apply(ti, te, "dstall0");
        te.sc = 16'd4; te.err = 1'b1;
        apply(ti, te, "dstall1");
        apply(idle_i, te, "dstall_hold0");
        apply(idle_i, te, "dstall_hold1");
        @(negedge clk);
        rst = 1'b1;
        #1;
        compare(zero_e, "dstall_rst");
        @(negedge clk);
        rst = 1'b0;

        // Fill every stage, then reset between edges
        apply('{1, 1, 0, 5'd5, 0, 0, 32'h0, 32'h0},
              '{5'd5, 1, 0, 5'd0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 16'd0, 16'd0, 0}, "fill0");
        apply('{1, 1, 1, 5'd3, 0, 0, 32'h99, 32'h0},
              '{5'd3, 1, 1, 5'd5, 1, 0, 5'd0, 0, 32'h99, 32'h0, 16'd0, 16'd0, 0}, "fill1");
        apply('{1, 1, 0, 5'd8, 0, 0, 32'hAB, 32'h55},
              '{5'd8, 1, 0, 5'd3, 1, 1, 5'd5, 1, 32'hAB, 32'h99, 16'd0, 16'd0, 0}, "fill2");
        apply('{1, 1, 0, 5'd2, 1, 1, 32'hCD, 32'h66},
              '{5'd0, 0, 0, 5'd8, 1, 0, 5'd3, 1, 32'hCD, 32'h66, 16'd1, 16'd1, 0}, "fill3");
        #1;
        rst = 1'b1;
        #1;
        compare(zero_e, "async_rst");
        @(negedge clk);
        rst = 1'b0;
        drive('{1, 1, 0, 5'd10, 0, 0, 32'h0, 32'h0});
        sb_q.push_back('{5'd10, 1, 0, 5'd0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 16'd0, 16'd0, 0});
        @(posedge clk);
        #1;
        pop_check("first_after_rst");

        // Counter saturation
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        ti = idle_i;
        ti.st = 1'b1;
        drive(ti);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_preload.stall_cnt", 32'(stall_cnt), 32'h0000FFFE);
        chk("sat_preload.flush_cnt", 32'(flush_cnt), 32'h0);
        ti.fl = 1'b1;
        @(negedge clk);
        drive(ti);
        repeat (3) @(posedge clk);
        #1;
        chk("sat.stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
        chk("sat.flush_cnt", 32'(flush_cnt), 32'd3);
        chk("sat.stall_err", 32'(stall_err), 32'd1);
        chk("sat.exe_wreg", 32'(exe_wreg), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_track.md
HAZARD_TRACK -- requirements
Module: hazard_track

Interface
REQ-001 SHALL provide `clk`, input, 1, the single rising-edge clock.
REQ-002 SHALL provide `rst`, input, 1, asynchronous active-high reset.
REQ-003 SHALL provide `id_valid`, input, 1, the decode stage holds a real instruction.
REQ-004 SHALL provide `id_wreg`, input, 1, the decoded instruction writes the register file.
REQ-005 SHALL provide `id_mem2reg`, input, 1, the decoded instruction is a load (writeback data comes from memory).
REQ-006 SHALL provide `id_regw_addr`, input, 5, the decoded destination register.
REQ-007 SHALL provide `stall`, input, 1, the load-use stall request from decode control.
REQ-008 SHALL provide `flush`, input, 1, kill the decode-stage instruction (taken branch or jump).
REQ-009 SHALL provide `exe_alu_result`, input, 32, the EXE-stage ALU output.
REQ-010 SHALL provide `mem_rdata`, input, 32, the data-memory read data in the MEM stage.
REQ-011 SHALL provide `exe_regw_addr`/`exe_wreg`/`exe_mem2reg`, outputs, 5/1/1, the EXE-stage destination tag.
REQ-012 SHALL provide `mem_regw_addr`/`mem_wreg`/`mem_mem2reg`, outputs, 5/1/1, the MEM-stage destination tag.
REQ-013 SHALL provide `wb_regw_addr`/`wb_wreg`, outputs, 5/1, the WB-stage destination tag.
REQ-014 SHALL provide `fwd_mem_data`, output, 32, the forwarding value for the MEM stage.
REQ-015 SHALL provide `fwd_wb_data`, output, 32, the forwarding value for the WB stage (register-file write data).
REQ-016 SHALL provide `stall_cnt`/`flush_cnt`, outputs, 16/16, saturating event counters.
REQ-017 SHALL provide `stall_err`, output, 1, a sticky flag for an illegal multi-cycle stall.

Function
REQ-018 SHALL register all tag, data and counter state on the rising edge of `clk`; every output is a register or a mux of registers.
REQ-019 SHALL load a bubble into EXE (`exe_wreg`=0, `exe_mem2reg`=0, `exe_regw_addr`=0) when `stall`, `flush`, or !`id_valid` is sampled high.
REQ-020 SHALL otherwise load EXE from the `id_*` inputs, forcing `exe_wreg`=0 and `exe_mem2reg`=0 when `id_regw_addr`==0, so $0 is never forwarded.
REQ-021 SHALL advance EXE to MEM unconditionally every cycle, and capture `exe_alu_result` into the internal `mem_alu`.
REQ-022 SHALL advance MEM to WB unconditionally every cycle, with `fwd_wb_data` <= `mem_mem2reg` ? `mem_rdata` : `mem_alu`.
REQ-023 SHALL drive `fwd_mem_data` combinationally as `mem_alu` (loads are not forwardable from MEM; the stall covers them).
REQ-024 SHALL give a tag one cycle of latency per stage: an ID instruction at edge N appears in EXE after N, in MEM after N+1 and in WB after N+2.
REQ-025 SHALL keep the MEM and WB stages advancing during `stall`; only EXE receives a bubble.
REQ-026 SHALL treat simultaneous `stall` and `flush` as a single bubble, with both counters incrementing.
REQ-027 SHALL increment `stall_cnt` by 1 on each cycle `stall`=1 and `flush_cnt` by 1 on each cycle `flush`=1, saturating at 16'hFFFF with no wrap.
REQ-028 SHALL register `stall` into `stall_q`, set `stall_err` when `stall`=1 and `stall_q`=1 (a load-use stall lasts exactly one cycle), and never clear it except by reset.

Reset
REQ-029 SHALL, on `rst`=1 asynchronously, drive all tags, `mem_alu`, `fwd_wb_data`, counters, `stall_q` and `stall_err` to 0, independent of `clk`.
REQ-030 SHALL load the first post-reset EXE entry from the ID inputs at the first rising edge with `rst`=0.
REQ-031 SHALL, on a reset asserted mid-pipeline, discard all in-flight tags, leaving no forwarding source valid afterward.

Verification
REQ-032 SHALL cover an ALU chain: ID add to r5 with `exe_alu_result`=32'h1234 -> `exe_regw_addr`=5 and `exe_wreg`=1, next cycle `fwd_mem_data`=32'h1234, following cycle `fwd_wb_data`=32'h1234 and `wb_regw_addr`=5.
REQ-033 SHALL cover a load-use case: lw to r3 with `mem_rdata`=32'hCAFE and `stall`=1 for one cycle -> EXE bubble, `mem_mem2reg`=1, `fwd_wb_data`=32'hCAFE, `stall_cnt`=1 and `stall_err`=0.
REQ-034 SHALL cover flush and $0: `flush`=1 with `id_wreg`=1 -> `exe_wreg`=0; `id_regw_addr`=0 with `id_wreg`=1 -> `exe_wreg`=0; `flush_cnt` increments by 1.
REQ-035 SHALL cover a double stall: `stall`=1 for 2 consecutive cycles -> `stall_err`=1, which stays 1 after `stall` drops and clears only on `rst`.
REQ-036 SHALL cover saturation: preload 65534 stalls, apply 3 more flush+stall cycles -> `stall_cnt`=16'hFFFF and `flush_cnt`=3.
REQ-037 SHALL cover an asynchronous reset: assert `rst` between clock edges with all stages valid -> all outputs read 0 before the next edge.
